// File: rtl/mem_process_engine.sv
// rtl/mem_process_engine.sv - host-triggered read-modify-write engine over the shared FPGA/PCIe RAM
// Optional run checksum accumulator: define MEM_PROC_CHECKSUM_EN.
module mem_process_engine #(
  parameter int DW = 32,
  parameter int AW = 21,
  parameter logic [AW-1:0] CMD_ADDR  = 21'h07FFFE,
  parameter logic [AW-1:0] BASE_ADDR = 21'h07FFFD,
  parameter logic [AW-1:0] LEN_ADDR  = 21'h07FFFC,
  parameter logic [AW-1:0] ADD_ADDR  = 21'h07FFFB,
  parameter int DEF_LEN = 999001
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pci_wr_en,
  input  logic [AW-1:0] pci_req_addr,
  input  logic [DW-1:0] pci_input_data,
  input  logic          mem_ready,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  output logic          rd_req,
  output logic          FPGA_wr_en,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] write_data,
  output logic          flag_we,
  output logic [DW-1:0] out_flag,
  output logic          busy,
  output logic [AW-1:0] progress,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, DONE, ABORT} state_t;

  localparam int NB = DW / 8;
  localparam logic [DW-1:0] START_CODE = DW'(32'h0001_0000);
  localparam logic [DW-1:0] ABORT_CODE = DW'(32'h0002_0000);
  localparam logic [DW-1:0] OP_MASK    = DW'(3);
  localparam logic [DW-1:0] FLAG_START = DW'(2);
  localparam logic [DW-1:0] FLAG_DONE  = DW'(4);
  localparam logic [DW-1:0] FLAG_ABORT = DW'(8);
  localparam logic [DW-1:0] FLAG_ERR   = DW'(16);
  localparam logic [AW-1:0] LEN_RESET  = AW'(DEF_LEN);
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [DW-1:0] ONE_D      = DW'(1);

  state_t        state;
  logic [AW-1:0] base;
  logic [AW-1:0] length;
  logic [DW-1:0] addend;
  logic [AW-1:0] addr;
  logic [AW-1:0] count;
  logic [DW-1:0] data;
  logic [1:0]    op;
  logic          abort_pend;
  logic          done_pulse;

  function automatic logic [DW-1:0] bswap(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = v[8*(NB-1-i) +: 8];
    return r;
  endfunction

  // op 0 is an increment of a little-endian word held in a big-endian view
  function automatic logic [DW-1:0] apply_op(input logic [1:0] o, input logic [DW-1:0] v,
                                             input logic [DW-1:0] add);
    logic [DW-1:0] r;
    case (o)
      2'd0:    r = bswap(bswap(v) + ONE_D);
      2'd1:    r = v + add;
      2'd2:    r = ~v;
      default: r = bswap(v);
    endcase
    return r;
  endfunction

  // The host is locked out during the DONE flag cycle even though the state is already IDLE
  logic host_ok, cmd_wr, is_start, is_abort, abort_now, abort_any;
  assign host_ok   = pci_wr_en && !done_pulse;
  assign cmd_wr    = host_ok && (pci_req_addr == CMD_ADDR);
  assign is_start  = (pci_input_data & ~OP_MASK) == START_CODE;
  assign is_abort  = pci_input_data == ABORT_CODE;
  assign abort_now = cmd_wr && is_abort;
  assign abort_any = abort_now || abort_pend;
  assign busy      = (state != IDLE);

`ifdef MEM_PROC_CHECKSUM_EN
  logic [DW-1:0] sum;
  assign checksum = sum;
`else
  assign checksum = '0;
`endif

  // Main sequencer: config/command decode, memory handshakes and flag reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      length     <= LEN_RESET;
      addend     <= ONE_D;
      addr       <= '0;
      count      <= '0;
      data       <= '0;
      op         <= '0;
      abort_pend <= 1'b0;
      done_pulse <= 1'b0;
      rd_req     <= 1'b0;
      FPGA_wr_en <= 1'b0;
      req_addr   <= '0;
      write_data <= '0;
      flag_we    <= 1'b0;
      out_flag   <= '0;
      progress   <= '0;
`ifdef MEM_PROC_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      flag_we    <= 1'b0;
      done_pulse <= 1'b0;
      if (abort_now && state != IDLE && state != DONE) abort_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (host_ok) begin
            if (pci_req_addr == BASE_ADDR) base   <= pci_input_data[AW-1:0];
            if (pci_req_addr == LEN_ADDR)  length <= pci_input_data[AW-1:0];
            if (pci_req_addr == ADD_ADDR)  addend <= pci_input_data;
          end
          if (cmd_wr) begin
            if (is_start) begin
              op         <= pci_input_data[1:0];
              addr       <= base;
              count      <= '0;
              progress   <= '0;
              abort_pend <= 1'b0;
              flag_we    <= 1'b1;
              out_flag   <= FLAG_START;
`ifdef MEM_PROC_CHECKSUM_EN
              sum        <= '0;
`endif
              if (length == '0) begin
                state <= DONE;
              end else begin
                state      <= RD_REQ;
                rd_req     <= 1'b1;
                FPGA_wr_en <= 1'b0;
                req_addr   <= base;
              end
            end else if (!is_abort) begin
              flag_we  <= 1'b1;
              out_flag <= FLAG_ERR;
            end
          end
        end
        RD_REQ: begin
          if (mem_ready) begin
            rd_req <= 1'b0;
            state  <= abort_any ? ABORT : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (abort_any) begin
            state <= ABORT;
          end else if (rd_valid) begin
            data  <= rd_data;
            state <= MODIFY;
          end
        end
        MODIFY: begin
          if (abort_any) begin
            state <= ABORT;
          end else begin
            data       <= apply_op(op, data, addend);
            write_data <= apply_op(op, data, addend);
            rd_req     <= 1'b1;
            FPGA_wr_en <= 1'b1;
            req_addr   <= addr;
            state      <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem_ready) begin
            count      <= count + ONE_A;
            progress   <= progress + ONE_A;
            addr       <= addr + ONE_A;
            FPGA_wr_en <= 1'b0;
`ifdef MEM_PROC_CHECKSUM_EN
            sum        <= sum + write_data;
`endif
            if (abort_any) begin
              rd_req <= 1'b0;
              state  <= ABORT;
            end else if (count + ONE_A == length) begin
              rd_req <= 1'b0;
              state  <= DONE;
            end else begin
              rd_req   <= 1'b1;
              req_addr <= addr + ONE_A;
              state    <= RD_REQ;
            end
          end
        end
        DONE: begin
          flag_we    <= 1'b1;
          out_flag   <= FLAG_DONE;
          req_addr   <= CMD_ADDR;
          count      <= '0;
          addr       <= '0;
          done_pulse <= 1'b1;
          state      <= IDLE;
        end
        ABORT: begin
          flag_we    <= 1'b1;
          out_flag   <= FLAG_ABORT;
          count      <= '0;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_process_engine.sv
// tb/tb_mem_process_engine.sv - randomized self-checking bench for mem_process_engine
module tb_mem_process_engine;
  localparam int DW = 32;
  localparam int AW = 21;
  localparam logic [AW-1:0] CMD_A  = 21'h07FFFE;
  localparam logic [AW-1:0] BASE_A = 21'h07FFFD;
  localparam logic [AW-1:0] LEN_A  = 21'h07FFFC;
  localparam logic [AW-1:0] ADD_A  = 21'h07FFFB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pci_wr_en = 1'b0;
  logic [AW-1:0] pci_req_addr = '0;
  logic [DW-1:0] pci_input_data = '0;
  logic mem_ready, rd_valid;
  logic [DW-1:0] rd_data;
  logic rd_req, FPGA_wr_en, flag_we, busy;
  logic [AW-1:0] req_addr, progress;
  logic [DW-1:0] write_data, out_flag, checksum;

  always #5 clk = ~clk;

  mem_process_engine dut (
    .clk(clk), .rst_n(rst_n), .pci_wr_en(pci_wr_en), .pci_req_addr(pci_req_addr),
    .pci_input_data(pci_input_data), .mem_ready(mem_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_req(rd_req), .FPGA_wr_en(FPGA_wr_en), .req_addr(req_addr),
    .write_data(write_data), .flag_we(flag_we), .out_flag(out_flag), .busy(busy),
    .progress(progress), .checksum(checksum)
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic [DW-1:0] mem [int];
  int ready_delay = 0;
  int rd_lat = 1;
  bit rand_mode = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int rd_acc = 0;
  int rdreq_cycles = 0;
  int stall_err = 0;
  logic [DW-1:0] flag_q[$];
  int flag_cyc_q[$];
  logic [DW-1:0] flag_ck_q[$];
  logic [AW-1:0] flag_pr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // flag monitor
  always @(negedge clk) begin
    if (rst_n && flag_we) begin
      flag_q.push_back(out_flag);
      flag_cyc_q.push_back(cyc);
      flag_ck_q.push_back(checksum);
      flag_pr_q.push_back(progress);
    end
  end

  // RAM responder: stalls mem_ready, returns reads after a latency, records writes
  initial begin : responder
    int stall, target, lat_cnt;
    bit pend, held, h_w;
    logic [AW-1:0] pend_a, h_a;
    logic [DW-1:0] h_d;
    stall = 0; target = 0; lat_cnt = 0; pend = 0; held = 0; h_w = 0;
    pend_a = '0; h_a = '0; h_d = '0;
    mem_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ready = 1'b0; rd_valid = 1'b0; pend = 0; held = 0;
      end else begin
        rd_valid = 1'b0;
        if (pend) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            rd_valid = 1'b1;
            rd_data = mem.exists(int'(pend_a)) ? mem[int'(pend_a)] : '0;
            pend = 0;
          end
        end
        if (mem_ready) begin
          mem_ready = 1'b0;
          held = 0;
        end
        if (rd_req) begin
          rdreq_cycles++;
          if (!held) begin
            held = 1; h_a = req_addr; h_w = FPGA_wr_en; h_d = write_data; stall = 0;
            target = rand_mode ? int'($urandom_range(0, 3)) : ready_delay;
          end else if (req_addr !== h_a || FPGA_wr_en !== h_w || (h_w && write_data !== h_d)) begin
            stall_err++;
          end
          if (stall == target) begin
            mem_ready = 1'b1;
            if (h_w) begin
              mem[int'(h_a)] = h_d;
              wr_addr_q.push_back(h_a);
              wr_data_q.push_back(h_d);
            end else begin
              rd_acc++;
              pend = 1; pend_a = h_a;
              lat_cnt = rand_mode ? int'($urandom_range(1, 4)) : rd_lat;
            end
          end
          stall++;
        end
      end
    end
  end

  function automatic logic [DW-1:0] model_op(input int op, input logic [DW-1:0] v, input logic [DW-1:0] add);
    logic [7:0] b [4];
    int c, s;
    for (int i = 0; i < 4; i++) b[i] = v[8*i +: 8];
    case (op)
      0: begin
        c = 1;
        for (int i = 3; i >= 0; i--) begin
          s = int'(b[i]) + c;
          b[i] = 8'(s % 256);
          c = s / 256;
        end
        return {b[3], b[2], b[1], b[0]};
      end
      1: return v + add;
      2: return ~v;
      default: return {b[0], b[1], b[2], b[3]};
    endcase
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : '0;
  endfunction

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pci_wr_en = 1'b1; pci_req_addr = a; pci_input_data = d;
    @(negedge clk);
    pci_wr_en = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete();
    flag_q.delete(); flag_cyc_q.delete(); flag_ck_q.delete(); flag_pr_q.delete();
    rd_acc = 0; rdreq_cycles = 0; stall_err = 0;
  endtask

  task automatic wait_flags(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (flag_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (flag_q.size() < n) $display("FAIL %s_timeout: flags seen %0d, required %0d", nm, flag_q.size(), n);
    else passed++;
  endtask

  task automatic run_check(input string nm, input logic [AW-1:0] base, input int len,
                           input int op, input logic [DW-1:0] add, input bit poke);
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] sum, exp_ck;
    logic [AW-1:0] a;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      exp_a.push_back(a);
      exp_d.push_back(model_op(op, mem_rd(a), add));
      sum = sum + exp_d[i];
    end
`ifdef MEM_PROC_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif
    clear_logs();
    host_write(BASE_A, DW'(base));
    host_write(LEN_A, DW'(len));
    host_write(ADD_A, add);
    host_write(CMD_A, 32'h0001_0000 | DW'(op));
    if (poke) begin
      host_write(LEN_A, 32'd1);
      host_write(BASE_A, 32'h123);
    end
    wait_flags(2, 20 * len + 40, nm);
    total++;
    if (flag_q.size() < 2 || flag_q[0] !== 32'd2 || flag_q[1] !== 32'd4)
      $display("FAIL %s_flags: got %0d flags first %h second %h, required 2 then 4", nm, flag_q.size(), flag_q[0], flag_q[1]);
    else passed++;
    total++;
    if (wr_data_q.size() != len) $display("FAIL %s_wr_count: got %0d, required %0d", nm, wr_data_q.size(), len);
    else passed++;
    for (int i = 0; i < len && i < wr_data_q.size(); i++) begin
      total++;
      if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i])
        $display("FAIL %s_write%0d: got %h@%h, required %h@%h", nm, i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
      else passed++;
    end
    total++;
    if (progress !== AW'(len) || busy !== 1'b0) $display("FAIL %s_progress: got %0d busy %b, required %0d busy 0", nm, progress, busy, len);
    else passed++;
    total++;
    if (flag_ck_q.size() < 2 || flag_ck_q[1] !== exp_ck) $display("FAIL %s_checksum: got %h, required %h", nm, flag_ck_q[1], exp_ck);
    else passed++;
    total++;
    if (stall_err !== 0) $display("FAIL %s_stable: got %0d unstable stall cycles, required 0", nm, stall_err);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rd_req, FPGA_wr_en, flag_we, busy} !== 4'b0 || req_addr !== '0 || write_data !== '0 ||
        out_flag !== '0 || progress !== '0 || checksum !== '0)
      $display("FAIL reset_outputs: got req %b wr %b flag %b busy %b addr %h, required all 0", rd_req, FPGA_wr_en, flag_we, busy, req_addr);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_op0_vectors();
    mem[32'h10] = 32'h0100_0000; mem[32'h11] = 32'hFF00_0000; mem[32'h12] = 32'hFFFF_FFFF;
    run_check("op0", 21'h10, 3, 0, 32'd7, 1'b0);
    total++;
    if (wr_data_q.size() < 3 || wr_data_q[0] !== 32'h0200_0000 || wr_data_q[1] !== 32'h0001_0000 || wr_data_q[2] !== 32'h0)
      $display("FAIL op0_vectors: got %h %h %h, required 02000000 00010000 00000000", wr_data_q[0], wr_data_q[1], wr_data_q[2]);
    else passed++;
  endtask

  task automatic test_wrap();
    mem[32'h1FFFFF] = 32'd5; mem[0] = 32'd7;
    run_check("wrap", 21'h1FFFFF, 2, 1, 32'h10, 1'b0);
    total++;
    if (wr_addr_q.size() < 2 || wr_addr_q[1] !== 21'h0 || wr_data_q[1] !== 32'h17 || wr_data_q[0] !== 32'h15)
      $display("FAIL wrap_vectors: got %h@%h %h@%h, required 15@1fffff 17@0", wr_data_q[0], wr_addr_q[0], wr_data_q[1], wr_addr_q[1]);
    else passed++;
  endtask

  task automatic test_stall();
    ready_delay = 3; rd_lat = 2;
    mem[32'h200] = 32'h0F0F_0F0F; mem[32'h201] = $urandom;
    run_check("stall", 21'h200, 2, 2, 32'd0, 1'b0);
    total++;
    if (wr_data_q.size() < 1 || wr_data_q[0] !== 32'hF0F0_F0F0) $display("FAIL stall_vector: got %h, required f0f0f0f0", wr_data_q[0]);
    else passed++;
    ready_delay = 0; rd_lat = 1;
  endtask

  task automatic test_len0();
    clear_logs();
    host_write(LEN_A, 32'd0);
    host_write(CMD_A, 32'h0001_0002);
    wait_flags(2, 10, "len0");
    repeat (2) @(negedge clk);
    total++;
    if (flag_q.size() != 2 || flag_q[0] !== 32'd2 || flag_q[1] !== 32'd4 || flag_cyc_q[1] - flag_cyc_q[0] != 1)
      $display("FAIL len0_flags: got %0d flags %h %h gap %0d, required 2 then 4 gap 1", flag_q.size(), flag_q[0], flag_q[1], flag_cyc_q[1] - flag_cyc_q[0]);
    else passed++;
    total++;
    if (rdreq_cycles != 0 || busy !== 1'b0) $display("FAIL len0_noreq: got %0d rd_req cycles busy %b, required 0 busy 0", rdreq_cycles, busy);
    else passed++;
  endtask

  task automatic test_abort();
    int k;
    for (int i = 0; i < 10; i++) mem[32'h300 + i] = $urandom;
    rd_lat = 6;
    clear_logs();
    host_write(BASE_A, 32'h300);
    host_write(LEN_A, 32'd10);
    host_write(CMD_A, 32'h0001_0001);
    k = 0;
    while (rd_acc < 6 && k < 400) begin
      @(negedge clk);
      k++;
    end
    host_write(CMD_A, 32'h0002_0000);
    wait_flags(2, 20, "abort");
    repeat (12) @(negedge clk);
    total++;
    if (flag_q.size() != 2 || flag_q[1] !== 32'd8) $display("FAIL abort_flag: got %0d flags last %h, required 2 flags last 8", flag_q.size(), flag_q[flag_q.size()-1]);
    else passed++;
    total++;
    if (wr_data_q.size() != 5 || progress !== 21'd5 || busy !== 1'b0)
      $display("FAIL abort_state: got %0d writes progress %0d busy %b, required 5 writes progress 5 busy 0", wr_data_q.size(), progress, busy);
    else passed++;
    rd_lat = 1;
    run_check("after_abort", 21'h400, 4, 3, 32'd0, 1'b0);
  endtask

  task automatic test_error();
    clear_logs();
    host_write(CMD_A, 32'h0001_0004);
    host_write(CMD_A, 32'h0003_0000 | DW'($urandom_range(0, 65535)));
    host_write(CMD_A, 32'h0002_0000);
    repeat (3) @(negedge clk);
    total++;
    if (flag_q.size() != 2 || flag_q[0] !== 32'h10 || flag_q[1] !== 32'h10)
      $display("FAIL error_flags: got %0d flags first %h, required two flags of 10", flag_q.size(), flag_q[0]);
    else passed++;
    total++;
    if (busy !== 1'b0 || rdreq_cycles != 0) $display("FAIL error_idle: got busy %b rd_req cycles %0d, required 0 and 0", busy, rdreq_cycles);
    else passed++;
  endtask

  task automatic test_random();
    logic [AW-1:0] b, a;
    int len, op;
    logic [DW-1:0] add;
    rand_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      b = AW'($urandom); len = $urandom_range(1, 8); op = $urandom_range(0, 3); add = $urandom;
      if (r == 0) b = 21'h1FFFFD;
      for (int i = 0; i < len; i++) begin
        a = b + AW'(i);
        mem[int'(a)] = $urandom;
      end
      run_check($sformatf("rand%0d", r), b, len, op, add, len >= 2);
    end
    rand_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] m0;
    clear_logs();
    host_write(BASE_A, 32'h500);
    host_write(LEN_A, 32'd50);
    host_write(CMD_A, 32'h0001_0002);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rd_req, FPGA_wr_en, flag_we, busy} !== 4'b0 || req_addr !== '0 || write_data !== '0 ||
        out_flag !== '0 || progress !== '0 || checksum !== '0)
      $display("FAIL async_reset: got req %b wr %b flag %b busy %b progress %0d, required all 0", rd_req, FPGA_wr_en, flag_we, busy, progress);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    m0 = $urandom;
    mem[0] = m0;
    clear_logs();
    host_write(CMD_A, 32'h0001_0001);
    repeat (300) @(negedge clk);
    total++;
    if (busy !== 1'b1 || wr_data_q.size() < 60 || progress !== AW'(wr_data_q.size()))
      $display("FAIL reset_length: got busy %b writes %0d progress %0d, required busy 1 with over 60 writes", busy, wr_data_q.size(), progress);
    else passed++;
    total++;
    if (wr_addr_q.size() < 1 || wr_addr_q[0] !== '0 || wr_data_q[0] !== m0 + 32'd1)
      $display("FAIL reset_base_addend: got %h@%h, required %h@0", wr_data_q[0], wr_addr_q[0], m0 + 32'd1);
    else passed++;
    host_write(CMD_A, 32'h0002_0000);
    wait_flags(2, 20, "reset_abort");
    total++;
    if (flag_q.size() < 2 || flag_q[flag_q.size()-1] !== 32'd8) $display("FAIL reset_abort_flag: got %h, required 8", flag_q[flag_q.size()-1]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_op0_vectors();
    test_wrap();
    test_stall();
    test_len0();
    test_abort();
    test_error();
    test_random();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
